pagerank_sched_ctrl: RTL and testbench

//  Sequences the pagerank_scatter engine over all graph partitions and iterations.
//  Per iteration, for each partition: select partition, run scatter to completion, run gather.

---
 rtl/pagerank_pkg.sv | 18 +
 rtl/pr_sched_wdog.sv | 31 +++
 rtl/pagerank_sched_ctrl.sv | 155 +++++++++++++++
 tb/tb_pagerank_sched_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pagerank_pkg.sv
// Shared types and constants for the PageRank partition/iteration scheduler.
package pagerank_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SCATTER,
    GATHER,
    ITER_END,
    DONE
  } sched_state_t;

  localparam int DEF_MAX_PARTITIONS = 16;
  localparam int PART_W             = $clog2(DEF_MAX_PARTITIONS) + 1;
  localparam int ITER_W             = 16;
  localparam int DEF_WDOG_CYCLES    = 4096;

endpackage

// File: rtl/pr_sched_wdog.sv
// Scatter/gather watchdog for pagerank_sched_ctrl; compiled only with PR_SCHED_WDOG_EN.
`ifdef PR_SCHED_WDOG_EN
module pr_sched_wdog #(
  parameter int CYCLES = 4096
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(CYCLES) + 1;

  logic [CW-1:0] cnt;

  // clear marks the first waiting cycle, so the count runs CYCLES-2 .. 0 over the rest
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= CW'(CYCLES - 2);
    end else if (run && cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign expired = run && !clear && (cnt == '0);

endmodule
`endif

// File: rtl/pagerank_sched_ctrl.sv
// Partition/iteration sequencer for the pagerank scatter and gather engines.
// Optional scatter/gather watchdog enabled by defining PR_SCHED_WDOG_EN.
module pagerank_sched_ctrl #(
  parameter int MAX_PARTITIONS = pagerank_pkg::DEF_MAX_PARTITIONS,
  parameter int ITER_W         = pagerank_pkg::ITER_W,
  parameter int WDOG_CYCLES    = pagerank_pkg::DEF_WDOG_CYCLES,
  parameter int PART_W         = $clog2(MAX_PARTITIONS) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [PART_W-1:0] num_partitions,
  input  logic [ITER_W-1:0] max_iterations,
  output logic              busy,
  output logic              done,
  output logic [ITER_W-1:0] iteration,
  output logic [PART_W-1:0] partition_idx,
  output logic              pagerank_enable,
  output logic              nextIteration,
  input  logic              scatter_complete,
  input  logic              scatter_output_ready,
  output logic              gather_start,
  input  logic              gather_done,
  output logic [31:0]       beat_count,
  output logic              timeout_err
);

  import pagerank_pkg::*;

  sched_state_t      state;
  logic [PART_W-1:0] num_lat;
  logic [ITER_W-1:0] max_lat;

`ifdef PR_SCHED_WDOG_EN
  logic wdog_clear;
  logic wdog_run;
  logic wdog_expired;

  assign wdog_run = (state == SCATTER) || (state == GATHER);

  pr_sched_wdog #(.CYCLES(WDOG_CYCLES)) u_wdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (wdog_clear),
    .run     (wdog_run),
    .expired (wdog_expired)
  );
`else
  logic [31:0] unused_wdog;
  assign unused_wdog = 32'(WDOG_CYCLES);
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      nextIteration   <= 1'b0;
      gather_start    <= 1'b0;
      pagerank_enable <= 1'b0;
      iteration       <= '0;
      partition_idx   <= '0;
      beat_count      <= '0;
      num_lat         <= '0;
      max_lat         <= '0;
`ifdef PR_SCHED_WDOG_EN
      wdog_clear      <= 1'b0;
      timeout_err     <= 1'b0;
`endif
    end else begin
      done          <= 1'b0;
      nextIteration <= 1'b0;
      gather_start  <= 1'b0;
`ifdef PR_SCHED_WDOG_EN
      wdog_clear    <= 1'b0;
`endif
      // abort leaves counters untouched so the host can inspect where the run stopped
      if (abort && state != IDLE) begin
        state           <= IDLE;
        busy            <= 1'b0;
        pagerank_enable <= 1'b0;
`ifdef PR_SCHED_WDOG_EN
      end else if (wdog_expired) begin
        state           <= IDLE;
        busy            <= 1'b0;
        pagerank_enable <= 1'b0;
        timeout_err     <= 1'b1;
`endif
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              num_lat       <= num_partitions;
              max_lat       <= max_iterations;
              iteration     <= '0;
              partition_idx <= '0;
              beat_count    <= '0;
              busy          <= 1'b1;
`ifdef PR_SCHED_WDOG_EN
              timeout_err   <= 1'b0;
`endif
              if (num_partitions == '0 || max_iterations == '0) state <= DONE;
              else state <= LOAD;
            end
          end
          LOAD: begin
            state           <= SCATTER;
            pagerank_enable <= 1'b1;
`ifdef PR_SCHED_WDOG_EN
            wdog_clear      <= 1'b1;
`endif
          end
          SCATTER: begin
            if (scatter_output_ready) beat_count <= beat_count + 32'd1;
            if (scatter_complete) begin
              state           <= GATHER;
              pagerank_enable <= 1'b0;
              gather_start    <= 1'b1;
`ifdef PR_SCHED_WDOG_EN
              wdog_clear      <= 1'b1;
`endif
            end
          end
          GATHER: begin
            if (gather_done) begin
              if (partition_idx + PART_W'(1) < num_lat) begin
                partition_idx <= partition_idx + PART_W'(1);
                state         <= LOAD;
              end else begin
                state         <= ITER_END;
                nextIteration <= 1'b1;
              end
            end
          end
          ITER_END: begin
            iteration     <= iteration + ITER_W'(1);
            partition_idx <= '0;
            beat_count    <= '0;
            if (iteration + ITER_W'(1) == max_lat) state <= DONE;
            else state <= LOAD;
          end
          DONE: begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pagerank_sched_ctrl.sv
// Self-checking bench for pagerank_sched_ctrl: randomized datapath responder plus counting model.
module tb_pagerank_sched_ctrl;

  localparam int PW = 5;
  localparam int IW = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          start, abort;
  logic [PW-1:0] num_partitions;
  logic [IW-1:0] max_iterations;
  logic          busy, done, pagerank_enable, nextIteration, gather_start, timeout_err;
  logic [IW-1:0] iteration;
  logic [PW-1:0] partition_idx;
  logic          scatter_complete, scatter_output_ready, gather_done;
  logic [31:0]   beat_count;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  pagerank_sched_ctrl #(.WDOG_CYCLES(16)) dut (
    .clock                (clock),
    .reset                (reset),
    .start                (start),
    .abort                (abort),
    .num_partitions       (num_partitions),
    .max_iterations       (max_iterations),
    .busy                 (busy),
    .done                 (done),
    .iteration            (iteration),
    .partition_idx        (partition_idx),
    .pagerank_enable      (pagerank_enable),
    .nextIteration        (nextIteration),
    .scatter_complete     (scatter_complete),
    .scatter_output_ready (scatter_output_ready),
    .gather_start         (gather_start),
    .gather_done          (gather_done),
    .beat_count           (beat_count),
    .timeout_err          (timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Acts as scatter/gather datapath for one run; the model counts the scatter runs,
  // iteration pulses and beats the rules imply for np partitions x mi iterations.
  task automatic run_job(input int np, input int mi, input int abort_at, input bit inject,
                         input string tag);
    int cyc = 0, runs = 0, iters = 0, dn = 0, beats_iter = 0;
    int cd = 0, bl = 0, gd = -1, en_cycles = 0, quiet = 0;
    int exp_iters;
    bit prev_en = 0, after_iter = 0, first_en = 0, ended = 0, aborted = 0;
    exp_iters = (np == 0 || mi == 0) ? 0 : mi;
    num_partitions = PW'(np);
    max_iterations = IW'(mi);
    start = 1'b1;
    step();
    start = 1'b0;
    check({tag, "_busy_after_start"}, busy, 1);
    while (!ended && cyc < 5000) begin
      if (after_iter) begin
        check({tag, "_beat_cleared"}, beat_count, 0);
        check({tag, "_iteration"}, iteration, iters);
        after_iter = 0;
      end
      if (pagerank_enable && !prev_en) begin
        runs++;
        if (!first_en) begin
          check({tag, "_enable_latency"}, cyc, 1);
          first_en = 1;
        end
        check({tag, "_partition"}, partition_idx, (runs - 1) % np);
        bl = $urandom_range(0, 4);
        cd = $urandom_range(0, 3);
        if (abort_at > 0) begin
          bl = 1;
          cd = $urandom_range(3, 5);
        end
        en_cycles = 0;
      end
      if (pagerank_enable) en_cycles++;
      prev_en = pagerank_enable;
      if (gather_start) gd = $urandom_range(1, 4);
      if (nextIteration) begin
        check({tag, "_beat_sum"}, beat_count, beats_iter);
        check({tag, "_last_partition"}, partition_idx, np - 1);
        iters++;
        beats_iter = 0;
        after_iter = 1;
      end
      if (done) begin
        dn++;
        ended = 1;
        if (np == 0 || mi == 0) check({tag, "_done_latency"}, cyc, 1);
        check({tag, "_busy_at_done"}, busy, 0);
      end
      scatter_output_ready = 1'b0;
      scatter_complete     = 1'b0;
      gather_done          = 1'b0;
      start                = 1'b0;
      if (!ended && abort_at > 0 && runs == 1 && pagerank_enable && en_cycles == abort_at) begin
        abort = 1'b1;
        step();
        abort = 1'b0;
        aborted = 1;
        ended = 1;
      end else if (!ended) begin
        if (pagerank_enable) begin
          if (bl > 0) begin
            scatter_output_ready = 1'b1;
            bl--;
            beats_iter++;
          end else if (cd > 0) cd--;
          else scatter_complete = 1'b1;
        end
        if (gd == 0) begin
          gather_done = 1'b1;
          gd = -1;
        end else if (gd > 0) gd--;
        if (inject && pagerank_enable && en_cycles == 1) gather_done = 1'b1;
        if (inject && gather_start) start = 1'b1;
        step();
        cyc++;
      end
    end
    scatter_output_ready = 1'b0;
    scatter_complete     = 1'b0;
    gather_done          = 1'b0;
    start                = 1'b0;
    check({tag, "_terminated"}, ended, 1);
    if (aborted) begin
      check({tag, "_abort_busy"}, busy, 0);
      check({tag, "_abort_enable"}, pagerank_enable, 0);
      check({tag, "_abort_beats_held"}, beat_count, beats_iter);
      check({tag, "_abort_partition_held"}, partition_idx, 0);
      check({tag, "_abort_iteration_held"}, iteration, 0);
      for (int i = 0; i < 10; i++) begin
        if (done || nextIteration || pagerank_enable) quiet++;
        step();
      end
      check({tag, "_abort_quiet"}, quiet, 0);
    end else begin
      check({tag, "_scatter_runs"}, runs, np * mi);
      check({tag, "_iter_pulses"}, iters, exp_iters);
      check({tag, "_done_pulses"}, dn, 1);
      check({tag, "_final_iteration"}, iteration, exp_iters);
      step();
      check({tag, "_done_single"}, done, 0);
      check({tag, "_idle_busy"}, busy, 0);
    end
  endtask

  initial begin
    int n;
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    num_partitions = '0;
    max_iterations = '0;
    scatter_complete = 1'b0;
    scatter_output_ready = 1'b0;
    gather_done = 1'b0;
    #12;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_enable", pagerank_enable, 0);
    check("reset_next", nextIteration, 0);
    check("reset_gstart", gather_start, 0);
    check("reset_iteration", iteration, 0);
    check("reset_partition", partition_idx, 0);
    check("reset_beats", beat_count, 0);
    check("reset_timeout", timeout_err, 0);
    @(negedge clock);
    reset = 1'b0;
    step();

    run_job(2, 3, 0, 0, "basic");
    run_job(2, 1, 0, 0, "beats");
    run_job(0, 3, 0, 0, "zero_np");
    run_job(3, 0, 0, 0, "zero_mi");
    run_job(2, 2, 2, 0, "abort");
    run_job(2, 2, 0, 0, "after_abort");
    run_job(3, 2, 0, 1, "inject");
    for (int k = 0; k < 4; k++) begin
      run_job($urandom_range(1, 4), $urandom_range(1, 3), 0, 0, "rand");
    end

`ifdef PR_SCHED_WDOG_EN
    num_partitions = 5'd1;
    max_iterations = 16'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    for (int i = 0; i < 100 && (busy || n == 0); i++) begin
      if (pagerank_enable) n++;
      step();
    end
    check("wdog_cycles", n, 16);
    check("wdog_timeout", timeout_err, 1);
    check("wdog_idle", busy, 0);
    run_job(1, 1, 0, 0, "wdog_restart");
    check("wdog_cleared", timeout_err, 0);
`else
    check("no_wdog_timeout", timeout_err, 0);
`endif

    num_partitions = 5'd2;
    max_iterations = 16'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    n = pagerank_enable;
    check("midrst_running", n, 1);
    #2 reset = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_enable", pagerank_enable, 0);
    check("midrst_beats", beat_count, 0);
    @(negedge clock);
    reset = 1'b0;
    step();
    check("midrst_no_done", done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
